// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader.
// Holds the loader FSM state type, the default memory depth and the checksum width.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
    StCsum,
    StRun,
    StErr
  } loader_state_e;

  localparam int unsigned DefaultMemWords = 1000;
  localparam int unsigned CsumW           = 8;

endpackage

// File: rtl/program_loader.sv
// Boot-time program loader.
// Accepts a byte stream {LEN_HI, LEN_LO, 2N data bytes (big-endian words), CSUM}.
// Each assembled word is written through a single memory write port. run is
// raised only after the checksum matches, and it holds the processor in reset
// until then.
// Ports:
//   clk, rst       clock and synchronous active-low reset
//   in_valid/in_data/in_ready  upstream byte handshake
//   mem_w/mem_addr/mem_wdata   registered memory write port, one pulse per word
//   run            verified image present (drives processor active-low reset)
//   done, error    load finished / load failed, both sticky until reset
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS = DefaultMemWords,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              run,
  output logic              done,
  output logic              error
);

  loader_state_e state_q, state_d;

  logic [7:0]        len_hi_q;
  logic [15:0]       len_q;
  logic [15:0]       word_cnt_q;
  logic [7:0]        hi_q;
  logic [CsumW-1:0]  csum_q;
  logic              mem_w_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [15:0]       mem_wdata_q;

  logic        accept;
  logic [15:0] len_in;
  logic        last_word;

  assign accept    = in_valid && in_ready;
  assign len_in    = {len_hi_q, in_data};
  // Word counter has not yet advanced for the word being completed.
  assign last_word = (word_cnt_q + 16'd1) == len_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StLenHi;
      StLenHi: if (accept) state_d = StLenLo;
      StLenLo: begin
        if (accept) begin
          if (len_in == 16'd0) begin
            state_d = StCsum;
          end else if ({16'd0, len_in} > MEM_WORDS) begin
            state_d = StErr;
          end else begin
            state_d = StDataHi;
          end
        end
      end
      StDataHi: if (accept) state_d = StDataLo;
      StDataLo: if (accept) state_d = last_word ? StCsum : StDataHi;
      StCsum:   if (accept) state_d = (in_data == csum_q) ? StRun : StErr;
      StRun:    state_d = StRun;
      StErr:    state_d = StErr;
      default:  state_d = StIdle;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready = 1'b0;
    run      = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state_q)
      StLenHi, StLenLo, StDataHi, StDataLo, StCsum: in_ready = 1'b1;
      StRun: begin
        run  = 1'b1;
        done = 1'b1;
      end
      StErr: begin
        done  = 1'b1;
        error = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: length, byte latch, word counter, checksum and write port
  always_ff @(posedge clk) begin
    if (!rst) begin
      len_hi_q    <= 8'd0;
      len_q       <= 16'd0;
      word_cnt_q  <= 16'd0;
      hi_q        <= 8'd0;
      csum_q      <= '0;
      mem_w_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 16'd0;
    end else begin
      mem_w_q <= 1'b0;
      if (state_q == StIdle) begin
        csum_q     <= '0;
        word_cnt_q <= 16'd0;
      end
      if (accept) begin
        // The checksum byte itself is compared, never accumulated.
        if (state_q != StCsum) begin
          csum_q <= csum_q + in_data;
        end
        unique case (state_q)
          StLenHi:  len_hi_q <= in_data;
          StLenLo:  len_q    <= len_in;
          StDataHi: hi_q     <= in_data;
          StDataLo: begin
            mem_w_q     <= 1'b1;
            mem_addr_q  <= ADDR_W'(word_cnt_q);
            mem_wdata_q <= {hi_q, in_data};
            word_cnt_q  <= word_cnt_q + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_w     = mem_w_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_w;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        run;
  logic        done;
  logic        error;

  int checks;
  int errors;

  int          wr_cnt;
  logic [15:0] wr_addr [0:3];
  logic [15:0] wr_data [0:3];

  logic [7:0]  strm [0:6];

  typedef struct packed {
    bit          restart;
    bit          v;
    logic [7:0]  d;
    bit          rdy;
    bit          w;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          run;
    bit          done;
    bit          err;
  } vec_t;

  localparam int NVec = 25;
  vec_t vecs [0:NVec-1];

  program_loader #(
    .MEM_WORDS(1000),
    .ADDR_W   (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_w    (mem_w),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .run      (run),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input bit v, input logic [7:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    if (mem_w) begin
      if (wr_cnt < 4) begin
        wr_addr[wr_cnt] = mem_addr;
        wr_data[wr_cnt] = mem_wdata;
      end
      wr_cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst mem_w", {31'd0, mem_w}, 32'd0);
    chk("rst mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst mem_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst run", {31'd0, run}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst error", {31'd0, error}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("idle in_ready", {31'd0, in_ready}, 32'd0);
    step(1'b0, 8'h00);
    chk("lenhi in_ready", {31'd0, in_ready}, 32'd1);
    wr_cnt = 0;
  endtask

  task automatic feed(input int first, input int n, input bit gaps);
    for (int i = first; i < first + n; i++) begin
      if (gaps) step(1'b0, 8'hFF);
      step(1'b1, strm[i]);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    wr_cnt   = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Words 0x1234, 0xABCD: 0x00+0x02+0x12+0x34+0xAB+0xCD = 0x1C0 -> CSUM 0xC0.
    //             restart v  data    rdy w  addr     wdata    run done err
    vecs[0]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'h34, 1'b1, 1'b1, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'hAB, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'hCD, 1'b1, 1'b1, 16'h0001, 16'hABCD, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'hC0, 1'b0, 1'b0, 16'h0001, 16'hABCD, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 16'h0001, 16'hABCD, 1'b1, 1'b1, 1'b0};
    // Same stream, bad checksum.
    vecs[8]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 8'h34, 1'b1, 1'b1, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 8'hAB, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 8'hCD, 1'b1, 1'b1, 16'h0001, 16'hABCD, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 8'h73, 1'b0, 1'b0, 16'h0001, 16'hABCD, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 8'hC0, 1'b0, 1'b0, 16'h0001, 16'hABCD, 1'b0, 1'b1, 1'b1};
    // N = 1001: rejected at LEN_LO.
    vecs[16] = '{1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 8'hE9, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1};
    // N = 0, CSUM 0x00.
    vecs[19] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0};
    // N = 1000 is the largest accepted length.
    vecs[23] = '{1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[24] = '{1'b0, 1'b1, 8'hE8, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < NVec; i++) begin
      if (vecs[i].restart) do_reset();
      step(vecs[i].v, vecs[i].d);
      chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].rdy});
      chk($sformatf("v%0d mem_w", i), {31'd0, mem_w}, {31'd0, vecs[i].w});
      chk($sformatf("v%0d mem_addr", i), {16'd0, mem_addr}, {16'd0, vecs[i].addr});
      chk($sformatf("v%0d mem_wdata", i), {16'd0, mem_wdata}, {16'd0, vecs[i].wdata});
      chk($sformatf("v%0d run", i), {31'd0, run}, {31'd0, vecs[i].run});
      chk($sformatf("v%0d done", i), {31'd0, done}, {31'd0, vecs[i].done});
      chk($sformatf("v%0d error", i), {31'd0, error}, {31'd0, vecs[i].err});
    end

    strm[0] = 8'h00; strm[1] = 8'h02; strm[2] = 8'h12; strm[3] = 8'h34;
    strm[4] = 8'hAB; strm[5] = 8'hCD; strm[6] = 8'hC0;

    // in_valid toggling every other cycle.
    do_reset();
    feed(0, 7, 1'b1);
    chk("gap wr_cnt", wr_cnt, 32'd2);
    chk("gap addr0", {16'd0, wr_addr[0]}, 32'h0000);
    chk("gap data0", {16'd0, wr_data[0]}, 32'h1234);
    chk("gap addr1", {16'd0, wr_addr[1]}, 32'h0001);
    chk("gap data1", {16'd0, wr_data[1]}, 32'hABCD);
    chk("gap run", {31'd0, run}, 32'd1);
    chk("gap error", {31'd0, error}, 32'd0);

    // Reset after the first word is written, then replay the whole stream.
    do_reset();
    feed(0, 4, 1'b0);
    chk("mid wr_cnt", wr_cnt, 32'd1);
    do_reset();
    feed(0, 6, 1'b0);
    chk("replay run before csum", {31'd0, run}, 32'd0);
    feed(6, 1, 1'b0);
    chk("replay wr_cnt", wr_cnt, 32'd2);
    chk("replay addr0", {16'd0, wr_addr[0]}, 32'h0000);
    chk("replay data0", {16'd0, wr_data[0]}, 32'h1234);
    chk("replay run", {31'd0, run}, 32'd1);
    chk("replay done", {31'd0, done}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
